// File: rtl/spi_reg_controller.sv
// spi_reg_controller: oversampled SPI mode-0 peripheral driving five PWM config registers.
// Define SPI_READBACK_EN to serve read frames on cipo; otherwise reads are dropped.
module spi_reg_controller #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_done
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] sclk_s_q, copi_s_q, ncs_s_q;
    logic                   sclk_d1_q, ncs_d1_q;
    logic                   sclk_sync, copi_sync, ncs_sync;
    logic                   sclk_rise, ncs_fall, ncs_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s_q  <= '0;
            copi_s_q  <= '0;
            ncs_s_q   <= '1;
            sclk_d1_q <= 1'b0;
            ncs_d1_q  <= 1'b1;
        end else begin
            sclk_s_q  <= {sclk_s_q[SYNC_STAGES-2:0], sclk};
            copi_s_q  <= {copi_s_q[SYNC_STAGES-2:0], copi};
            ncs_s_q   <= {ncs_s_q[SYNC_STAGES-2:0], ncs};
            sclk_d1_q <= sclk_sync;
            ncs_d1_q  <= ncs_sync;
        end
    end

    assign sclk_sync = sclk_s_q[SYNC_STAGES-1];
    assign copi_sync = copi_s_q[SYNC_STAGES-1];
    assign ncs_sync  = ncs_s_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_sync & ~sclk_d1_q;
    assign ncs_fall  = ~ncs_sync & ncs_d1_q;
    assign ncs_rise  = ncs_sync & ~ncs_d1_q;

    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  regs_q [5];
    logic        addr_ok, wr_en;

    assign addr_ok = int'(shift_q[14:8]) <= MAX_ADDR;

`ifdef SPI_READBACK_EN
    logic       sclk_fall;
    logic [7:0] out_q, out_d;
    logic       cipo_q, cipo_d, rd_q, rd_d;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;

    assign sclk_fall = ~sclk_sync & sclk_d1_q;
    // Address as it will stand once the 8th bit lands in the shift reg.
    assign rd_addr   = {shift_q[5:0], copi_sync};

    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < 5; i++) begin
            if (rd_addr == 7'(i) && i <= MAX_ADDR) rd_data = regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= 8'h00;
            cipo_q <= 1'b0;
            rd_q   <= 1'b0;
        end else begin
            out_q  <= out_d;
            cipo_q <= cipo_d;
            rd_q   <= rd_d;
        end
    end

    assign cipo = cipo_q;
`else
    assign cipo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= 16'h0000;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        wr_en      = 1'b0;
        frame_done = 1'b0;
`ifdef SPI_READBACK_EN
        out_d      = out_q;
        cipo_d     = cipo_q;
        rd_d       = rd_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef SPI_READBACK_EN
                cipo_d = 1'b0;
                rd_d   = 1'b0;
`endif
                if (ncs_fall) begin
                    state_d = SHIFT;
                    shift_d = 16'h0000;
                    cnt_d   = 5'd0;
                end
            end
            SHIFT: begin
                // ncs_rise wins over a coincident sclk edge.
                if (ncs_rise) begin
                    state_d = COMMIT;
                end else if (sclk_rise && !ncs_sync) begin
                    shift_d = {shift_q[14:0], copi_sync};
                    cnt_d   = (cnt_q == 5'd17) ? 5'd17 : cnt_q + 5'd1;
`ifdef SPI_READBACK_EN
                    if (cnt_q == 5'd7 && !shift_q[6]) begin
                        out_d = rd_data;
                        rd_d  = 1'b1;
                    end
`endif
                end
`ifdef SPI_READBACK_EN
                else if (sclk_fall && rd_q) begin
                    cipo_d = out_q[7];
                    out_d  = {out_q[6:0], 1'b0};
                end
`endif
            end
            COMMIT: begin
                state_d = IDLE;
                if (cnt_q == 5'd16) begin
                    wr_en      = shift_q[15] & addr_ok;
                    frame_done = shift_q[15] ? addr_ok : RB;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) regs_q[i] <= 8'h00;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (wr_en && shift_q[14:8] == 7'(i)) regs_q[i] <= shift_q[7:0];
            end
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];

endmodule
